// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck program loader: FSM encoding, frame sync byte, checksum width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bf_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         CSUM_W    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        LEN       = 3'd2,
        DATA      = 3'd3,
        CSUM      = 3'd4,
        START     = 3'd5,
        ERR       = 3'd6
    } state_t;

endpackage

// File: rtl/bf_prog_loader.sv
// Loads a framed program (A5, N, N opcodes, XOR checksum) from a UART byte stream into program memory.
// Latency: one write strobe the cycle after each data byte; start_o one cycle after a good checksum.
// Backpressure: none, the stream cannot be stalled; optional inter-byte timeout under LOADER_TIMEOUT_EN.
module bf_prog_loader
    import bf_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              cpu_busy_i,
    output logic              prog_we_o,
    output logic [ADDR_W-1:0] prog_waddr_o,
    output logic [7:0]        prog_wdata_o,
    output logic              halt_o,
    output logic              start_o,
    output logic              loading_o,
    output logic              err_o
);

    localparam int CNT_W   = ADDR_W + 1;
    localparam int MAX_LEN = 1 << ADDR_W;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [7:0]          len_q;
    logic [CSUM_W-1:0]   csum_q;
    logic                err_q;
    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [7:0]          wdata_q;
    logic                sync_hit;
    logic                len_bad;
    logic                last_byte;
    logic                tmo_hit;

    assign sync_hit  = rx_valid_i && (rx_data_i == SYNC_BYTE);
    assign len_bad   = (rx_data_i == 8'd0) || (int'(rx_data_i) > MAX_LEN);
    assign last_byte = (int'(cnt_q) + 1) == int'(len_q);

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tmo_q;

    // Counts silent cycles while a frame body is expected; any byte or leaving the body restarts it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tmo_q <= '0;
        end else if (rx_valid_i || !(state_q inside {LEN, DATA, CSUM})) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end

    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYC));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (sync_hit) state_d = HALT_WAIT;
            HALT_WAIT: begin
                if (rx_valid_i)       state_d = ERR;
                else if (!cpu_busy_i) state_d = LEN;
            end
            LEN: begin
                if (rx_valid_i)   state_d = len_bad ? ERR : DATA;
                else if (tmo_hit) state_d = ERR;
            end
            DATA: begin
                if (rx_valid_i)   state_d = last_byte ? CSUM : DATA;
                else if (tmo_hit) state_d = ERR;
            end
            CSUM: begin
                if (rx_valid_i)   state_d = (rx_data_i == csum_q) ? START : ERR;
                else if (tmo_hit) state_d = ERR;
            end
            START:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            len_q   <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_hit) begin
                        err_q  <= 1'b0;
                        csum_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                LEN: begin
                    if (rx_valid_i && !len_bad) begin
                        len_q  <= rx_data_i;
                        csum_q <= csum_q ^ rx_data_i;
                    end
                end
                DATA: begin
                    // Writes are committed immediately; an error later in the frame leaves them in place.
                    if (rx_valid_i) begin
                        we_q    <= 1'b1;
                        waddr_q <= cnt_q[ADDR_W-1:0];
                        wdata_q <= rx_data_i;
                        cnt_q   <= cnt_q + 1'b1;
                        csum_q  <= csum_q ^ rx_data_i;
                    end
                end
                ERR:     err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign prog_we_o    = we_q;
    assign prog_waddr_o = waddr_q;
    assign prog_wdata_o = wdata_q;
    assign halt_o       = (state_q != IDLE);
    assign loading_o    = (state_q != IDLE);
    assign start_o      = (state_q == START);
    assign err_o        = err_q;

endmodule

// File: tb/tb_bf_prog_loader.sv
// Self-checking bench for bf_prog_loader with a frame-level reference model.
// Timeout scenario is included when LOADER_TIMEOUT_EN is defined.
module tb_bf_prog_loader;
    import bf_pkg::*;

    localparam int ADDR_W = 3;
    localparam int NMAX   = 1 << ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              cpu_busy_i;
    logic              prog_we_o;
    logic [ADDR_W-1:0] prog_waddr_o;
    logic [7:0]        prog_wdata_o;
    logic              halt_o;
    logic              start_o;
    logic              loading_o;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    bf_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(100)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .cpu_busy_i(cpu_busy_i), .prog_we_o(prog_we_o), .prog_waddr_o(prog_waddr_o),
        .prog_wdata_o(prog_wdata_o), .halt_o(halt_o), .start_o(start_o),
        .loading_o(loading_o), .err_o(err_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Observed write strobes ({addr,data}) and start pulses.
    logic [ADDR_W+7:0] got_w[$];
    int                start_cnt = 0;

    always @(negedge clk_i) begin
        if (prog_we_o) got_w.push_back({prog_waddr_o, prog_wdata_o});
        if (start_o) start_cnt++;
    end

    // Reference model state for one frame.
    logic [7:0]        frame[$];
    logic [ADDR_W+7:0] exp_w[$];
    int                exp_start;
    logic              exp_err;

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] cs;
        frame.delete();
        frame.push_back(SYNC_BYTE);
        frame.push_back(8'(n));
        if (n >= 1 && n <= NMAX) begin
            cs = 8'(n);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                frame.push_back(b);
                cs ^= b;
            end
            frame.push_back(corrupt ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
        end
    endtask

    // Expected outcome of a frame, from the frame rules alone.
    task automatic model_frame();
        int n;
        logic [7:0] cs;
        exp_w.delete();
        exp_start = 0;
        exp_err   = 1'b0;
        n = int'(frame[1]);
        if (n == 0 || n > NMAX) begin
            exp_err = 1'b1;
        end else begin
            cs = frame[1];
            for (int i = 0; i < n; i++) begin
                exp_w.push_back({ADDR_W'(i), frame[2+i]});
                cs ^= frame[2+i];
            end
            if (frame[2+n] == cs) exp_start = 1;
            else                  exp_err   = 1'b1;
        end
    endtask

    // Called at a negedge; returns at a negedge after gap idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic send_frame(input bit tight);
        for (int i = 0; i < frame.size(); i++) begin
            int gap;
            if (tight) gap = (i == 0 || i == frame.size() - 1) ? 1 : 0;
            else       gap = $urandom_range(1, 3);
            send_byte(frame[i], gap);
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic clear_obs();
        got_w.delete();
        start_cnt = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00; cpu_busy_i = 1'b0;
        repeat (3) @(negedge clk_i);
        vectors++; if (prog_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", prog_we_o); end
        vectors++; if (prog_waddr_o !== '0) begin miscompares++; $display("FAIL reset_waddr got %0d want 0", prog_waddr_o); end
        vectors++; if (prog_wdata_o !== 8'h00) begin miscompares++; $display("FAIL reset_wdata got %h want 00", prog_wdata_o); end
        vectors++; if (halt_o !== 1'b0) begin miscompares++; $display("FAIL reset_halt got %b want 0", halt_o); end
        vectors++; if (start_o !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b want 0", start_o); end
        vectors++; if (loading_o !== 1'b0) begin miscompares++; $display("FAIL reset_loading got %b want 0", loading_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_good_frame();
        clear_obs();
        frame = '{8'hA5, 8'h02, 8'h2B, 8'h2E, 8'h07};
        send_frame(1'b0);
        vectors++; if (got_w.size() !== 2) begin miscompares++; $display("FAIL good_nwr got %0d want 2", got_w.size()); end
        if (got_w.size() == 2) begin
            vectors++; if (got_w[0] !== {3'd0, 8'h2B}) begin miscompares++; $display("FAIL good_wr0 got %h want 02b", got_w[0]); end
            vectors++; if (got_w[1] !== {3'd1, 8'h2E}) begin miscompares++; $display("FAIL good_wr1 got %h want 12e", got_w[1]); end
        end
        vectors++; if (start_cnt !== 1) begin miscompares++; $display("FAIL good_start got %0d want 1", start_cnt); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL good_err got %b want 0", err_o); end
        vectors++; if (halt_o !== 1'b0) begin miscompares++; $display("FAIL good_halt got %b want 0", halt_o); end
    endtask

    task automatic test_bad_csum();
        clear_obs();
        frame = '{8'hA5, 8'h02, 8'h2B, 8'h2E, 8'h06};
        send_frame(1'b0);
        vectors++; if (got_w.size() !== 2) begin miscompares++; $display("FAIL badcs_nwr got %0d want 2", got_w.size()); end
        vectors++; if (start_cnt !== 0) begin miscompares++; $display("FAIL badcs_start got %0d want 0", start_cnt); end
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL badcs_err got %b want 1", err_o); end
        vectors++; if (loading_o !== 1'b0) begin miscompares++; $display("FAIL badcs_loading got %b want 0", loading_o); end
        send_byte(8'h3C, 2);
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL badcs_sticky got %b want 1", err_o); end
        send_byte(SYNC_BYTE, 2);
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL badcs_clear got %b want 0", err_o); end
        vectors++; if (halt_o !== 1'b1) begin miscompares++; $display("FAIL badcs_halt got %b want 1", halt_o); end
        clear_obs();
        send_byte(8'h01, 1); send_byte(8'h55, 1); send_byte(8'h54, 3);
        vectors++; if (start_cnt !== 1) begin miscompares++; $display("FAIL badcs_recover got %0d want 1", start_cnt); end
    endtask

    task automatic test_busy_wait();
        clear_obs();
        cpu_busy_i = 1'b1;
        repeat (20) @(negedge clk_i);
        send_byte(SYNC_BYTE, 10);
        vectors++; if (halt_o !== 1'b1) begin miscompares++; $display("FAIL busy_halt got %b want 1", halt_o); end
        vectors++; if (loading_o !== 1'b1) begin miscompares++; $display("FAIL busy_loading got %b want 1", loading_o); end
        cpu_busy_i = 1'b0;
        repeat (2) @(negedge clk_i);
        send_byte(8'h01, 1); send_byte(8'h3E, 1); send_byte(8'h3F, 3);
        vectors++; if (got_w.size() !== 1) begin miscompares++; $display("FAIL busy_nwr got %0d want 1", got_w.size()); end
        if (got_w.size() == 1) begin
            vectors++; if (got_w[0] !== {3'd0, 8'h3E}) begin miscompares++; $display("FAIL busy_wr0 got %h want 03e", got_w[0]); end
        end
        vectors++; if (start_cnt !== 1) begin miscompares++; $display("FAIL busy_start got %0d want 1", start_cnt); end
        vectors++; if (halt_o !== 1'b0) begin miscompares++; $display("FAIL busy_release got %b want 0", halt_o); end
    endtask

    task automatic test_len_bounds();
        int lens[2] = '{0, NMAX + 1};
        foreach (lens[k]) begin
            clear_obs();
            build_frame(lens[k], 1'b0);
            send_frame(1'b0);
            vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL len%0d_err got %b want 1", lens[k], err_o); end
            vectors++; if (got_w.size() !== 0) begin miscompares++; $display("FAIL len%0d_nwr got %0d want 0", lens[k], got_w.size()); end
            vectors++; if (start_cnt !== 0) begin miscompares++; $display("FAIL len%0d_start got %0d want 0", lens[k], start_cnt); end
        end
        clear_obs();
        build_frame(NMAX, 1'b0);
        model_frame();
        send_frame(1'b0);
        vectors++; if (got_w.size() !== NMAX) begin miscompares++; $display("FAIL lenmax_nwr got %0d want %0d", got_w.size(), NMAX); end
        for (int i = 0; i < NMAX && i < got_w.size(); i++) begin
            vectors++; if (got_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL lenmax_wr%0d got %h want %h", i, got_w[i], exp_w[i]); end
        end
        vectors++; if (start_cnt !== 1) begin miscompares++; $display("FAIL lenmax_start got %0d want 1", start_cnt); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL lenmax_err got %b want 0", err_o); end
    endtask

    task automatic test_random(input int iters, input bit tight);
        for (int it = 0; it < iters; it++) begin
            int n;
            int noise;
            clear_obs();
            noise = tight ? 0 : $urandom_range(0, 2);
            for (int j = 0; j < noise; j++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b == SYNC_BYTE) b = 8'h5A;
                send_byte(b, 1);
            end
            if (!tight && $urandom_range(0, 9) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(NMAX + 1, 255);
            else
                n = $urandom_range(1, NMAX);
            build_frame(n, !tight && ($urandom_range(0, 3) == 0));
            model_frame();
            send_frame(tight);
            vectors++; if (got_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL rnd%0d_nwr got %0d want %0d", it, got_w.size(), exp_w.size()); end
            for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
                vectors++; if (got_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL rnd%0d_wr%0d got %h want %h", it, i, got_w[i], exp_w[i]); end
            end
            vectors++; if (start_cnt !== exp_start) begin miscompares++; $display("FAIL rnd%0d_start got %0d want %0d", it, start_cnt, exp_start); end
            vectors++; if (err_o !== exp_err) begin miscompares++; $display("FAIL rnd%0d_err got %b want %b", it, err_o, exp_err); end
            vectors++; if (loading_o !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_loading got %b want 0", it, loading_o); end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        send_byte(SYNC_BYTE, 1); send_byte(8'h04, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
        vectors++; if (got_w.size() !== 2) begin miscompares++; $display("FAIL rstmid_pre got %0d want 2", got_w.size()); end
        clear_obs();
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        vectors++; if (halt_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_halt got %b want 0", halt_o); end
        vectors++; if (loading_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_loading got %b want 0", loading_o); end
        vectors++; if ({prog_we_o, prog_waddr_o, prog_wdata_o, start_o, err_o} !== '0) begin
            miscompares++; $display("FAIL rstmid_outs got %b want 0", {prog_we_o, prog_waddr_o, prog_wdata_o, start_o, err_o});
        end
        send_byte(8'h33, 1); send_byte(8'h44, 1); send_byte(8'h40, 3);
        vectors++; if (got_w.size() !== 0) begin miscompares++; $display("FAIL rstmid_nwr got %0d want 0", got_w.size()); end
        vectors++; if (start_cnt !== 0) begin miscompares++; $display("FAIL rstmid_start got %0d want 0", start_cnt); end
        vectors++; if (halt_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got %b want 0", halt_o); end
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        clear_obs();
        send_byte(SYNC_BYTE, 1); send_byte(8'h03, 1); send_byte(8'h2B, 50);
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL tmo_early got %b want 0", err_o); end
        repeat (60) @(negedge clk_i);
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL tmo_err got %b want 1", err_o); end
        vectors++; if (loading_o !== 1'b0) begin miscompares++; $display("FAIL tmo_loading got %b want 0", loading_o); end
        vectors++; if (got_w.size() !== 1) begin miscompares++; $display("FAIL tmo_nwr got %0d want 1", got_w.size()); end
    endtask
`endif

    initial begin
        rst_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00; cpu_busy_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_busy_wait();
        test_len_bounds();
        test_random(30, 1'b0);
        test_random(6, 1'b1);
        test_reset_mid();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
